mult_nxn_seq: RTL and testbench
===============================

Name: mult_nxn_seq

Overview:
- Parametrised successor to the 8x8 sequential multiplier: WIDTH x WIDTH multiply, unsigned or two's-complement selected per operation.
- Built on one 4x4 nibble multiplier reused over multiple cycles; product, done flag and a state-digit 7-segment display are kept.
- Sits in the datapath behind a start/done handshake and drives one on-board 7-segment digit.

Parameters:
- WIDTH, 8: operand width; must be a multiple of 4, range 4..16. K = WIDTH/4 nibbles per operand.
- SIGNED_EN, 1: 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_a  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- signed_mode  in  1  1 = operands are two's complement; sampled with start.
- dataa  in  WIDTH  multiplicand; sampled with start.
- datab  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high in MAC and FIX.
- done_flag  out  1  high in DONE.
- product  out  2*WIDTH  registered result.
- seg_a..seg_g  out  1 each  active-high 7-segment lines showing state digit.

Behaviour:
- Reset (reset_a = 0, asynchronous): state = IDLE, busy = 0, done_flag = 0, product = 0, accumulator = 0, counters = 0, display = '0'.
- States and digits: IDLE = '0', MAC = '1', FIX = '2', DONE = '3'.
- Segment patterns: '0' = a b c d e f; '1' = b c; '2' = a b d e g; '3' = a b c d g.
- IDLE/DONE with start = 1 at edge t:
  - Latch operands and mode. In signed mode, store magnitudes (unsigned WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1)) and neg = sign(a) XOR sign(b).
  - Clear the accumulator, clear done_flag, go to MAC with i = j = 0.
- MAC: one step per cycle for K*K cycles.
  - Each step: acc += (nib_a[i] * nib_b[j]) << 4*(i+j).
  - j increments fastest; i increments when j wraps.
  - Accumulator width is 2*WIDTH; no overflow is possible.
- FIX (1 cycle):
  - product <= neg ? -acc : acc (2*WIDTH two's complement).
  - In unsigned mode, product <= acc.
  - FIX is always executed, so latency is constant.
- DONE: done_flag = 1. product holds until the next accepted start completes FIX. Stays in DONE until start.
- Latency: done_flag rises K*K + 2 edges after the accepting edge (WIDTH = 8: 6 cycles; WIDTH = 16: 18 cycles).
- Boundaries:
  - start while busy is ignored; operands changing during MAC have no effect.
  - start held high continuously: each DONE lasts exactly 1 cycle before the next operation is accepted.
  - product keeps its old value during MAC/FIX and updates only at the FIX edge.
  - reset_a low mid-operation aborts immediately to the reset values; no partial product is exposed.
  - Zero operands and the most-negative operand follow the normal path; no special casing.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, MAC, FIX, DONE);
  - 7-bit segment constants SEG_0..SEG_3 (bit order a..g);
  - function clog2 for counter widths.
- Sub-module mult_4x4_comb: purely combinational 4x4 -> 8-bit unsigned multiplier, instantiated once.
- The segment decode is a small case statement in the top level.

Test Plan:
- Reset with random inputs, then reset_a 0 -> 1: product = 0, done_flag = 0, busy = 0, segments = '0' (1111110).
- WIDTH=8, unsigned, 50 * 10, start for 1 cycle -> busy for 5 cycles, done_flag high on cycle 6, product = 500 (0x01F4), segments = '3'.
- WIDTH=8, unsigned 255 * 255 -> 0xFE01. Signed -128 * -128 -> 0x4000. Signed -7 * 3 -> 0xFFEB. Signed -128 * 1 -> 0xFF80.
- Back-to-back: 10 * 5 then, while DONE, start 7 * 3 -> product 50, then 21. A start pulse with new operands during MAC is ignored and the result is unchanged.
- reset_a pulsed low at MAC cycle 2 -> same-cycle return to IDLE, product = 0, busy = 0. A following 7 * 3 -> 21.
- WIDTH=16 instance, unsigned 0xFFFF * 0xFFFF -> 0xFFFE0001 with done_flag at cycle 18. SIGNED_EN=0 with signed_mode = 1: 0xFF * 0x02 -> 0x01FE.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state enum, segment codes and width helper for the nibble multiplier
package mult_pkg;

  // Controller states; the display digit equals the state's position.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Active-high segment patterns, bit 6 = a down to bit 0 = g.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;

  // Ceiling log2, used to size the nibble index counters.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_nxn_seq_if.sv
// rtl/mult_nxn_seq_if.sv - start/done handshake and operand/result bus of the multiplier
interface mult_nxn_seq_if #(
  parameter int WIDTH = 8
);

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     dataa;
  logic [WIDTH-1:0]     datab;
  logic                 busy;
  logic                 done_flag;
  logic [2*WIDTH-1:0]   product;

  // Requester side: issues operands and start, watches busy/done/product.
  modport master (
    output start,
    output signed_mode,
    output dataa,
    output datab,
    input  busy,
    input  done_flag,
    input  product
  );

  // Multiplier side.
  modport slave (
    input  start,
    input  signed_mode,
    input  dataa,
    input  datab,
    output busy,
    output done_flag,
    output product
  );

endinterface

// File: rtl/mult_4x4_comb.sv
// rtl/mult_4x4_comb.sv - combinational 4x4 unsigned nibble multiplier
module mult_4x4_comb (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [7:0] pp0;
  logic [7:0] pp1;
  logic [7:0] pp2;
  logic [7:0] pp3;

  // Shift-and-add of four gated partial products.
  always_comb begin
    pp0 = b[0] ? {4'b0000, a}         : 8'h00;
    pp1 = b[1] ? {3'b000, a, 1'b0}    : 8'h00;
    pp2 = b[2] ? {2'b00, a, 2'b00}    : 8'h00;
    pp3 = b[3] ? {1'b0, a, 3'b000}    : 8'h00;
    p   = pp0 + pp1 + pp2 + pp3;
  end

endmodule

// File: rtl/mult_nxn_seq.sv
// rtl/mult_nxn_seq.sv - WIDTH x WIDTH sequential multiplier reusing one 4x4 nibble multiplier
module mult_nxn_seq
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset_a,
  mult_nxn_seq_if.slave bus,
  output logic          seg_a,
  output logic          seg_b,
  output logic          seg_c,
  output logic          seg_d,
  output logic          seg_e,
  output logic          seg_f,
  output logic          seg_g
);

  localparam int K  = WIDTH / 4;
  localparam int PW = 2 * WIDTH;
  // A single-nibble operand still needs a 1-bit counter.
  localparam int CW = (clog2(K) < 1) ? 1 : clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t          state;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic            neg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   idx_i;
  logic [CW-1:0]   idx_j;
  logic            busy_r;
  logic            done_r;
  logic [PW-1:0]   product_r;
  logic [6:0]      seg;

  logic            eff_signed;
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;
  logic            in_neg;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [7:0]      nib_prod;
  logic [CW:0]     dig_sum;
  logic [PW-1:0]   term;
  logic [PW-1:0]   acc_next;

  // Operand conditioning at start: magnitudes plus a result sign; -2^(W-1) maps to 2^(W-1).
  always_comb begin
    eff_signed = SIGNED_EN && bus.signed_mode;
    in_mag_a   = (eff_signed && bus.dataa[WIDTH-1]) ? -bus.dataa : bus.dataa;
    in_mag_b   = (eff_signed && bus.datab[WIDTH-1]) ? -bus.datab : bus.datab;
    in_neg     = eff_signed && (bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1]);
  end

  // Current nibble pair and its weighted contribution to the accumulator.
  always_comb begin
    nib_a    = mag_a[{idx_i, 2'b00} +: 4];
    nib_b    = mag_b[{idx_j, 2'b00} +: 4];
    dig_sum  = {1'b0, idx_i} + {1'b0, idx_j};
    term     = PW'(nib_prod) << {dig_sum, 2'b00};
    acc_next = acc + term;
  end

  mult_4x4_comb u_nib_mul (
    .a (nib_a),
    .b (nib_b),
    .p (nib_prod)
  );

  // Controller: accept in IDLE/DONE, K*K accumulate steps, one fix-up cycle, then DONE.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state     <= IDLE;
      mag_a     <= '0;
      mag_b     <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            neg    <= in_neg;
            acc    <= '0;
            idx_i  <= '0;
            idx_j  <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (idx_j == LAST) begin
            idx_j <= '0;
            if (idx_i == LAST) begin
              idx_i <= '0;
              state <= FIX;
            end else begin
              idx_i <= idx_i + 1'b1;
            end
          end else begin
            idx_j <= idx_j + 1'b1;
          end
        end
        FIX: begin
          // Runs in unsigned mode too so latency never depends on the data.
          product_r <= neg ? -acc : acc;
          busy_r    <= 1'b0;
          done_r    <= 1'b1;
          state     <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // State digit decode for the on-board display.
  always_comb begin
    seg = SEG_0;
    case (state)
      IDLE:    seg = SEG_0;
      MAC:     seg = SEG_1;
      FIX:     seg = SEG_2;
      DONE:    seg = SEG_3;
      default: seg = SEG_0;
    endcase
  end

  assign bus.busy      = busy_r;
  assign bus.done_flag = done_r;
  assign bus.product   = product_r;

  assign seg_a = seg[6];
  assign seg_b = seg[5];
  assign seg_c = seg[4];
  assign seg_d = seg[3];
  assign seg_e = seg[2];
  assign seg_f = seg[1];
  assign seg_g = seg[0];

endmodule

// File: tb/tb_mult_nxn_seq.sv
// tb/tb_mult_nxn_seq.sv - self-checking bench for the sequential nibble multiplier
module tb_mult_nxn_seq;

  localparam logic [6:0] DIG0 = 7'b1111110;
  localparam logic [6:0] DIG1 = 7'b0110000;
  localparam logic [6:0] DIG2 = 7'b1101101;
  localparam logic [6:0] DIG3 = 7'b1111001;

  logic       clk = 1'b0;
  logic       reset_a;
  logic [6:0] seg8;
  logic [6:0] seg16;
  logic [6:0] segu;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mult_nxn_seq_if #(.WIDTH(8))  if8 ();
  mult_nxn_seq_if #(.WIDTH(16)) if16 ();
  mult_nxn_seq_if #(.WIDTH(8))  ifu ();

  mult_nxn_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .reset_a(reset_a), .bus(if8),
    .seg_a(seg8[6]), .seg_b(seg8[5]), .seg_c(seg8[4]), .seg_d(seg8[3]),
    .seg_e(seg8[2]), .seg_f(seg8[1]), .seg_g(seg8[0])
  );

  mult_nxn_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
    .clk(clk), .reset_a(reset_a), .bus(if16),
    .seg_a(seg16[6]), .seg_b(seg16[5]), .seg_c(seg16[4]), .seg_d(seg16[3]),
    .seg_e(seg16[2]), .seg_f(seg16[1]), .seg_g(seg16[0])
  );

  mult_nxn_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dutu (
    .clk(clk), .reset_a(reset_a), .bus(ifu),
    .seg_a(segu[6]), .seg_b(segu[5]), .seg_c(segu[4]), .seg_d(segu[3]),
    .seg_e(segu[2]), .seg_f(segu[1]), .seg_g(segu[0])
  );

  // Reference: integer product of the operands as numbers, reduced to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic sgn,
                                          input logic [15:0] a, input logic [15:0] b);
    longint m;
    longint av;
    longint bv;
    longint p;
    m  = (longint'(1) << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (sgn && av[w-1]) av = av - (longint'(1) << w);
    if (sgn && bv[w-1]) bv = bv - (longint'(1) << w);
    p = (av * bv) & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  function automatic logic [31:0] prod_of(input int d);
    case (d)
      0:       return {16'h0000, if8.product};
      1:       return if16.product;
      default: return {16'h0000, ifu.product};
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return if8.busy;
      1:       return if16.busy;
      default: return ifu.busy;
    endcase
  endfunction

  function automatic logic done_of(input int d);
    case (d)
      0:       return if8.done_flag;
      1:       return if16.done_flag;
      default: return ifu.done_flag;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return seg8;
      1:       return seg16;
      default: return segu;
    endcase
  endfunction

  task automatic drive(input int d, input logic st, input logic sm,
                       input logic [15:0] a, input logic [15:0] b);
    case (d)
      0: begin
        if8.start = st; if8.signed_mode = sm; if8.dataa = a[7:0]; if8.datab = b[7:0];
      end
      1: begin
        if16.start = st; if16.signed_mode = sm; if16.dataa = a; if16.datab = b;
      end
      default: begin
        ifu.start = st; ifu.signed_mode = sm; ifu.dataa = a[7:0]; ifu.datab = b[7:0];
      end
    endcase
  endtask

  // One operation: 1-cycle start pulse, then observe until done (bounded).
  // edges counts rising edges from the accepting edge inclusive; poke_at > 0
  // fires a second start with different operands at that edge count.
  task automatic run(input int d, input logic sm, input logic [15:0] a, input logic [15:0] b,
                     input int poke_at, output logic [31:0] prod, output int edges,
                     output int busy_cycles, output int hold_bad,
                     output logic [6:0] seg_mac, output logic [6:0] seg_fix);
    logic [31:0] prev;
    prev = prod_of(d);
    @(negedge clk);
    drive(d, 1'b1, sm, a, b);
    @(negedge clk);
    drive(d, 1'b0, sm, a, b);
    edges = 1; busy_cycles = 0; hold_bad = 0; seg_mac = '0; seg_fix = '0;
    while (!done_of(d) && edges < 100) begin
      if (busy_of(d)) busy_cycles++;
      if (prod_of(d) !== prev) hold_bad++;
      if (edges == 1) seg_mac = seg_of(d);
      seg_fix = seg_of(d);
      if (poke_at > 0 && edges == poke_at) drive(d, 1'b1, ~sm, ~a, a ^ b);
      else if (poke_at > 0 && edges == poke_at + 1) drive(d, 1'b0, ~sm, ~a, a ^ b);
      @(negedge clk);
      edges++;
    end
    prod = prod_of(d);
  endtask

  task automatic test_reset();
    reset_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 3; d++)
        drive(d, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (prod_of(d) !== 32'h0) begin
        n_err++; $display("FAIL reset_product[%0d] got %0h want 0", d, prod_of(d));
      end
      n_cmp++;
      if (busy_of(d) !== 1'b0) begin
        n_err++; $display("FAIL reset_busy[%0d] got %b want 0", d, busy_of(d));
      end
      n_cmp++;
      if (done_of(d) !== 1'b0) begin
        n_err++; $display("FAIL reset_done[%0d] got %b want 0", d, done_of(d));
      end
      n_cmp++;
      if (seg_of(d) !== DIG0) begin
        n_err++; $display("FAIL reset_seg[%0d] got %b want %b", d, seg_of(d), DIG0);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] p; int e; int bc; int hb; logic [6:0] sm; logic [6:0] sf;
    run(0, 1'b0, 16'd50, 16'd10, 0, p, e, bc, hb, sm, sf);
    n_cmp++;
    if (p !== 32'd500) begin n_err++; $display("FAIL basic_product got %0h want %0h", p, 500); end
    n_cmp++;
    if (e !== 6) begin n_err++; $display("FAIL basic_latency got %0d want 6", e); end
    n_cmp++;
    if (bc !== 5) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 5", bc); end
    n_cmp++;
    if (hb !== 0) begin n_err++; $display("FAIL basic_product_hold got %0d changes want 0", hb); end
    n_cmp++;
    if (sm !== DIG1) begin n_err++; $display("FAIL basic_seg_mac got %b want %b", sm, DIG1); end
    n_cmp++;
    if (sf !== DIG2) begin n_err++; $display("FAIL basic_seg_fix got %b want %b", sf, DIG2); end
    n_cmp++;
    if (seg8 !== DIG3) begin n_err++; $display("FAIL basic_seg_done got %b want %b", seg8, DIG3); end
    @(negedge clk);
    n_cmp++;
    if (if8.done_flag !== 1'b1) begin
      n_err++; $display("FAIL basic_done_holds got %b want 1", if8.done_flag);
    end
  endtask

  task automatic test_corners();
    logic [31:0] p; int e; int bc; int hb; logic [6:0] sm; logic [6:0] sf;
    logic        t_sgn [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] t_a   [6] = '{16'h00FF, 16'h0080, 16'h00F9, 16'h0080, 16'h0000, 16'h0000};
    logic [15:0] t_b   [6] = '{16'h00FF, 16'h0080, 16'h0003, 16'h0001, 16'h0080, 16'h00FF};
    logic [31:0] t_exp [6] = '{32'hFE01, 32'h4000, 32'hFFEB, 32'hFF80, 32'h0000, 32'h0000};
    for (int k = 0; k < 6; k++) begin
      run(0, t_sgn[k], t_a[k], t_b[k], 0, p, e, bc, hb, sm, sf);
      n_cmp++;
      if (p !== t_exp[k]) begin
        n_err++; $display("FAIL corner[%0d] got %0h want %0h", k, p, t_exp[k]);
      end
    end
  endtask

  task automatic test_random8();
    logic [31:0] p; int e; int bc; int hb; logic [6:0] sm; logic [6:0] sf;
    logic s; logic [15:0] a; logic [15:0] b; logic [31:0] exp_p;
    for (int k = 0; k < 20; k++) begin
      s = 1'($urandom); a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255));
      exp_p = ref_mul(8, s, a, b);
      run(0, s, a, b, 0, p, e, bc, hb, sm, sf);
      n_cmp++;
      if (p !== exp_p || e !== 6) begin
        n_err++; $display("FAIL rand8[%0d] s=%b %0h*%0h got %0h lat %0d want %0h lat 6", k, s, a, b, p, e, exp_p);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p; int e; int bc; int hb; logic [6:0] sm; logic [6:0] sf;
    run(0, 1'b0, 16'd10, 16'd5, 0, p, e, bc, hb, sm, sf);
    n_cmp++;
    if (p !== 32'd50) begin n_err++; $display("FAIL b2b_first got %0d want 50", p); end
    run(0, 1'b0, 16'd7, 16'd3, 0, p, e, bc, hb, sm, sf);
    n_cmp++;
    if (p !== 32'd21 || e !== 6) begin
      n_err++; $display("FAIL b2b_second got %0d lat %0d want 21 lat 6", p, e);
    end
    n_cmp++;
    if (hb !== 0) begin n_err++; $display("FAIL b2b_hold got %0d changes want 0", hb); end
    run(0, 1'b0, 16'd100, 16'd3, 2, p, e, bc, hb, sm, sf);
    n_cmp++;
    if (p !== 32'd300 || e !== 6) begin
      n_err++; $display("FAIL ignore_mid_mac got %0d lat %0d want 300 lat 6", p, e);
    end
    @(negedge clk);
    n_cmp++;
    if (if8.done_flag !== 1'b1 || if8.product !== 16'd300) begin
      n_err++; $display("FAIL ignore_mid_mac_after got done %b prod %0d want 1 300", if8.done_flag, if8.product);
    end
  endtask

  task automatic test_start_held();
    int w;
    drive(0, 1'b1, 1'b1, 16'h00F9, 16'h0003);
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      w = 0;
      while (!if8.done_flag && w < 50) begin @(negedge clk); w++; end
      n_cmp++;
      if (if8.product !== 16'hFFEB) begin
        n_err++; $display("FAIL held_product[%0d] got %0h want ffeb", rep, if8.product);
      end
      @(negedge clk);
      n_cmp++;
      if (if8.done_flag !== 1'b0 || if8.busy !== 1'b1) begin
        n_err++; $display("FAIL held_done_one_cycle[%0d] got done %b busy %b want 0 1", rep, if8.done_flag, if8.busy);
      end
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    w = 0;
    while (!if8.done_flag && w < 50) begin @(negedge clk); w++; end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] p; int e; int bc; int hb; logic [6:0] sm; logic [6:0] sf;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd200, 16'd100);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd200, 16'd100);
    @(negedge clk);
    #2 reset_a = 1'b0;
    #1;
    n_cmp++;
    if (if8.busy !== 1'b0 || if8.done_flag !== 1'b0) begin
      n_err++; $display("FAIL midreset_flags got busy %b done %b want 0 0", if8.busy, if8.done_flag);
    end
    n_cmp++;
    if (if8.product !== 16'h0) begin n_err++; $display("FAIL midreset_product got %0h want 0", if8.product); end
    n_cmp++;
    if (seg8 !== DIG0) begin n_err++; $display("FAIL midreset_seg got %b want %b", seg8, DIG0); end
    @(negedge clk);
    reset_a = 1'b1;
    run(0, 1'b0, 16'd7, 16'd3, 0, p, e, bc, hb, sm, sf);
    n_cmp++;
    if (p !== 32'd21) begin n_err++; $display("FAIL midreset_next got %0d want 21", p); end
  endtask

  task automatic test_width16();
    logic [31:0] p; int e; int bc; int hb; logic [6:0] sm; logic [6:0] sf;
    logic s; logic [15:0] a; logic [15:0] b; logic [31:0] exp_p;
    run(1, 1'b0, 16'hFFFF, 16'hFFFF, 0, p, e, bc, hb, sm, sf);
    n_cmp++;
    if (p !== 32'hFFFE0001) begin n_err++; $display("FAIL w16_max got %0h want fffe0001", p); end
    n_cmp++;
    if (e !== 18 || bc !== 17) begin
      n_err++; $display("FAIL w16_latency got %0d busy %0d want 18 busy 17", e, bc);
    end
    for (int k = 0; k < 6; k++) begin
      s = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      if (k == 0) begin s = 1'b1; a = 16'h8000; b = 16'h8000; end
      exp_p = ref_mul(16, s, a, b);
      run(1, s, a, b, 0, p, e, bc, hb, sm, sf);
      n_cmp++;
      if (p !== exp_p) begin
        n_err++; $display("FAIL rand16[%0d] s=%b %0h*%0h got %0h want %0h", k, s, a, b, p, exp_p);
      end
    end
  endtask

  task automatic test_signed_disabled();
    logic [31:0] p; int e; int bc; int hb; logic [6:0] sm; logic [6:0] sf;
    logic [15:0] a; logic [15:0] b; logic [31:0] exp_p;
    run(2, 1'b1, 16'h00FF, 16'h0002, 0, p, e, bc, hb, sm, sf);
    n_cmp++;
    if (p !== 32'h01FE) begin n_err++; $display("FAIL nosign_ff_x_2 got %0h want 1fe", p); end
    for (int k = 0; k < 4; k++) begin
      a = 16'($urandom_range(128, 255)); b = 16'($urandom_range(0, 255));
      exp_p = ref_mul(8, 1'b0, a, b);
      run(2, 1'b1, a, b, 0, p, e, bc, hb, sm, sf);
      n_cmp++;
      if (p !== exp_p) begin
        n_err++; $display("FAIL nosign_rand[%0d] %0h*%0h got %0h want %0h", k, a, b, p, exp_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random8();
    test_back_to_back();
    test_start_held();
    test_reset_mid_op();
    test_width16();
    test_signed_disabled();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
